// File: rtl/ecc_mult_pkg.sv
// Shared constants and types for the ECC multiplier datapath chunk interfaces.
// Used by both the result serializer and the receive-side chunk loader.
package ecc_mult_pkg;

   localparam int DATA_W     = 238;
   localparam int CHUNK_W    = 17;
   localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
   localparam int IDX_W      = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/result_serializer.sv
// Streams one parallel field element out as CHUNK_W-bit chunks, LSB chunk first,
// over a valid/ready interface; a top-shifting chunk loader rebuilds the word.
module result_serializer #(
   parameter int DATA_W  = ecc_mult_pkg::DATA_W,
   parameter int CHUNK_W = ecc_mult_pkg::CHUNK_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic [DATA_W-1:0]              din,
   output logic                           load_ready,
   output logic [CHUNK_W-1:0]             out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [ecc_mult_pkg::IDX_W-1:0] chunk_idx,
   output logic                           done
);
   import ecc_mult_pkg::*;

   localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   generate
      if (DATA_W % CHUNK_W != 0) begin : g_width_check
         $error("result_serializer: DATA_W must be an exact multiple of CHUNK_W");
      end
   endgenerate

   ser_state_t        r_state;
   ser_state_t        w_state_nxt;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] w_shreg_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      w_last      = (r_state == SEND) && (r_idx == LAST_IDX);

      case (r_state)
         IDLE: begin
            w_idx_nxt = '0;
            if (load) begin
               w_shreg_nxt = din;
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            // An index past the last chunk can only come from an upset; abandon the word.
            if (r_idx > LAST_IDX) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end else if (out_ready) begin
               w_shreg_nxt = r_shreg >> CHUNK_W;
               if (r_idx == LAST_IDX) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign load_ready = (r_state == IDLE);
   assign out_valid  = (r_state == SEND);
   assign out_last   = w_last;
   assign out_data   = r_shreg[CHUNK_W-1:0];
   assign chunk_idx  = r_idx;
   assign done       = r_done;

endmodule

// File: doc/result_serializer.md
# result_serializer

Transmit-side counterpart of the 17-bit chunk loader feeding the ECC multiplier datapath. Accepts one 238-bit field element in parallel and streams it out as fourteen 17-bit chunks over a valid/ready interface, least-significant chunk first. The ordering is chosen so that a chunk loader which shifts each new chunk in at the top and moves existing contents toward the LSB rebuilds the identical 238-bit word after fourteen transfers. The block sits between the multiplier result register and the narrow bus toward the host or the next pipeline stage.

## Interface
- DATA_W, 238, width of the parallel operand.
- CHUNK_W, 17, width of one output chunk.
- NUM_CHUNKS, DATA_W/CHUNK_W = 14, derived and not overridable. DATA_W must be an exact multiple of CHUNK_W; elaboration fails otherwise.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  request to capture din.
- din  in  DATA_W  parallel word to serialize.
- load_ready  out  1  high when the block is in IDLE and will accept load.
- out_data  out  CHUNK_W  current chunk.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_last  out  1  high together with out_valid when the current chunk is chunk 13.
- chunk_idx  out  4  index of the current chunk, 0..13.
- done  out  1  single-cycle pulse after the final chunk is accepted.

## Operation
- The FSM has two states: IDLE and SEND.
- IDLE:
  - load_ready=1, out_valid=0.
  - When load=1, capture din into a DATA_W shift register, set chunk_idx=0, and go to SEND.
- SEND:
  - out_data = shreg[CHUNK_W-1:0]; out_valid=1; load_ready=0.
  - A transfer occurs when out_valid & out_ready. On a transfer:
    - shreg shifts right by CHUNK_W with zero fill.
    - chunk_idx increments.
  - On the transfer of chunk 13:
    - chunk_idx returns to 0.
    - The state returns to IDLE.
    - done=1 for exactly the following cycle.
- load while in SEND is ignored: no capture, no error.
- load in IDLE during the cycle where done=1 is accepted, so back-to-back words are supported.
- Out-of-range chunk_idx (14, 15) is unreachable. If it is ever reached, the FSM forces IDLE.

## Timing
- Reset values:
  - state=IDLE, shreg=0, chunk_idx=0.
  - out_valid=0, out_last=0, done=0, load_ready=1, out_data=0.
- Load latency: load accepted in cycle N → out_valid=1 with chunk 0 in cycle N+1.
- Throughput: with out_ready held high, chunks 0..13 appear in cycles N+1..N+14, and done=1 in cycle N+15.
  - If load is asserted in cycle N+15, the next word's chunk 0 appears in N+16, so one word is handled every 15 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, chunk_idx and out_last hold stable for any number of cycles.
- out_ready is ignored when out_valid=0.
- done is registered and never coincides with out_valid=1 for the same word.
- Reset mid-operation: on the edge where rst=1, the block returns to reset values regardless of state or handshake.
  - No done pulse is issued.
  - Any partial word is discarded.
- rst has priority over load and out_ready in the same cycle.

## Structure
- Shared package ecc_mult_pkg holds:
  - the constants DATA_W=238, CHUNK_W=17, NUM_CHUNKS=14, IDX_W=4;
  - the state enum typedef ser_state_t {IDLE, SEND}.
- The chunk loader on the receive side uses the same package constants.
- Single module with no sub-modules. The shift register, counter and FSM are small enough to stay flat.

## Test plan
- Reset then load, with din = 238'h1 | (238'h2<<17) | … (chunk k = k+1), out_ready=1:
  - Chunks 0x00001..0x0000E appear in 14 consecutive cycles.
  - out_last is high only on 0x0000E.
  - done pulses exactly one cycle later.
- Random out_ready backpressure (about 50% duty) on a random din:
  - Reassembling the chunks LSB-first equals din.
  - out_data never changes while valid & !ready.
- Loopback into the chunk loader (sel = valid & ready):
  - After done, the loader output equals the original din for 100 random words.
- load asserted continuously during SEND with a different din:
  - The output stream still matches the first word.
  - The second word is captured only in the done cycle.
- rst asserted after chunk 5:
  - The next cycle shows out_valid=0, chunk_idx=0, load_ready=1.
  - done is never asserted.
  - A fresh load then streams correctly.
- Back-to-back loads, all-ones din followed by all-zeros din:
  - 28 chunks are emitted (0x1FFFF ×14, then 0x00000 ×14).
  - There is exactly one idle cycle between the two words.
